obs_ctrl: RTL and testbench

OBS_CTRL -- requirements
Module: obs_ctrl

---
 rtl/obs_pkg.sv | 28 ++
 rtl/obs_ctrl_if.sv | 32 +++
 rtl/lfsr8.sv | 31 +++
 rtl/obs_ctrl.sv | 129 ++++++++++++
 tb/tb_obs_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/obs_pkg.sv
// Shared definitions for the obstacle controller.
// The package holds the FSM state encoding, the LFSR feedback taps, the
// number of obstacle slots, and the saturating gap-reload helper.
package obs_pkg;

    // Encoding 2'd3 is unused. The FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Fibonacci taps for x^8 + x^6 + x^5 + x^4 + 1 (register bits 7, 5, 4, 3).
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Number of obstacle slots held by the controller.
    localparam int N_SLOTS = 2;

    // Reload value for the gap counter after a spawn.
    // The result is min_gap + rnd, clamped to 8'hFF instead of wrapping.
    function automatic logic [7:0] gap_reload(input logic [7:0] min_gap,
                                              input logic [3:0] rnd);
        logic [8:0] sum;
        sum = {1'b0, min_gap} + {5'd0, rnd};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/obs_ctrl_if.sv
// Bus between the game logic and the obstacle controller.
//   i_frame_tick : one-cycle pulse per video frame
//   i_start      : pulse that starts or restarts a run
//   i_collide    : level from the collision logic; halts the game
//   i_speed      : leftward step applied on each frame tick
//   o_xpos0/1    : slot x positions, in half-pixel units
//   o_active0/1  : the slot holds a visible obstacle
//   o_spawn      : one-cycle pulse when a slot is loaded
//   o_state      : current FSM state
// The master modport is the driving side. The slave modport is the controller.
interface obs_ctrl_if;
    logic       i_frame_tick;
    logic       i_start;
    logic       i_collide;
    logic [3:0] i_speed;
    logic [8:0] o_xpos0;
    logic [8:0] o_xpos1;
    logic       o_active0;
    logic       o_active1;
    logic       o_spawn;
    logic [1:0] o_state;

    modport master (
        output i_frame_tick, i_start, i_collide, i_speed,
        input  o_xpos0, o_xpos1, o_active0, o_active1, o_spawn, o_state
    );

    modport slave (
        input  i_frame_tick, i_start, i_collide, i_speed,
        output o_xpos0, o_xpos1, o_active0, o_active1, o_spawn, o_state
    );
endinterface

// File: rtl/lfsr8.sv
// 8-bit free-running Fibonacci LFSR.
// It advances on every clock and reloads SEED on reset.
//   clk : system clock
//   rst : synchronous, active-high reset
//   rnd : low nibble of the register, used to randomise spawn gaps
// SEED must be non-zero, otherwise the register locks at zero.
module lfsr8
    import obs_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] rnd
);

    logic [7:0] q;

    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

    assign rnd = q[3:0];

endmodule

// File: rtl/obs_ctrl.sv
// Obstacle controller for the runner game.
// The controller moves up to N_SLOTS obstacles leftward on each frame tick,
// retires obstacles that reach the left edge, and spawns new ones at SPAWN_X.
// Spawns are separated by at least MIN_GAP ticks plus a random 0..15 ticks.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : obs_ctrl_if.slave; the game inputs and obstacle outputs
module obs_ctrl
    import obs_pkg::*;
#(
    parameter logic [8:0] SPAWN_X   = 9'd320,
    parameter logic [7:0] MIN_GAP   = 8'd20,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input logic        clk,
    input logic        rst,
    obs_ctrl_if.slave  bus
);

    state_t               state_q, state_d;
    logic [8:0]           xpos_q [N_SLOTS];
    logic [8:0]           xpos_d [N_SLOTS];
    logic [N_SLOTS-1:0]   active_q, active_d;
    logic [7:0]           gap_q, gap_d;
    logic                 spawn_q, spawn_d;
    logic                 found;
    logic [3:0]           lfsr_rnd;

    lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .rnd (lfsr_rnd)
    );

    // NOTE: every variable written in this block gets a default first.
    // A path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d  = state_q;
        xpos_d   = xpos_q;
        active_d = active_q;
        gap_d    = gap_q;
        spawn_d  = 1'b0;
        found    = 1'b0;

        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (bus.i_start) begin
                    state_d  = ST_RUN;
                    active_d = '0;
                    gap_d    = MIN_GAP;
                    for (int i = 0; i < N_SLOTS; i++) begin
                        xpos_d[i] = '0;
                    end
                end
            end

            ST_RUN: begin
                // Collide takes priority over the tick, so the positions
                // freeze at their pre-edge values.
                if (bus.i_collide) begin
                    state_d = ST_HALT;
                end else if (bus.i_frame_tick) begin
                    // Move active slots. A slot that would pass the left
                    // edge retires at 0 instead of wrapping.
                    for (int i = 0; i < N_SLOTS; i++) begin
                        if (active_q[i]) begin
                            if (xpos_q[i] < {5'd0, bus.i_speed}) begin
                                active_d[i] = 1'b0;
                                xpos_d[i]   = '0;
                            end else begin
                                xpos_d[i] = xpos_q[i] - {5'd0, bus.i_speed};
                            end
                        end
                    end

                    // A slot freed on this same tick may be reused at once.
                    // The spawned slot skips this tick's motion.
                    if (gap_q == 8'd0) begin
                        for (int i = 0; i < N_SLOTS; i++) begin
                            if (!found && !active_d[i]) begin
                                found       = 1'b1;
                                active_d[i] = 1'b1;
                                xpos_d[i]   = SPAWN_X;
                            end
                        end
                        // With every slot busy the counter stays at 0, so
                        // the spawn happens on the first tick a slot frees.
                        if (found) begin
                            gap_d   = gap_reload(MIN_GAP, lfsr_rnd);
                            spawn_d = 1'b1;
                        end
                    end else begin
                        gap_d = gap_q - 8'd1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slot registers are reset as well, because they
            // drive visible outputs and feed the retire/spawn decisions.
            state_q  <= ST_IDLE;
            active_q <= '0;
            gap_q    <= MIN_GAP;
            spawn_q  <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                xpos_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            xpos_q   <= xpos_d;
            active_q <= active_d;
            gap_q    <= gap_d;
            spawn_q  <= spawn_d;
        end
    end

    assign bus.o_xpos0   = xpos_q[0];
    assign bus.o_xpos1   = xpos_q[1];
    assign bus.o_active0 = active_q[0];
    assign bus.o_active1 = active_q[1];
    assign bus.o_spawn   = spawn_q;
    assign bus.o_state   = state_q;

endmodule

// File: tb/tb_obs_ctrl.sv
// Self-checking bench for obs_ctrl.
// A behavioural model of the game rules runs beside the DUT. Every output is
// compared with the model on each falling edge. Directed scenarios pin known
// values, and a randomised phase follows.
module tb_obs_ctrl;

    localparam int SPAWN_X = 320;
    localparam int MIN_GAP = 20;
    localparam int SEED    = 'hA5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    obs_ctrl_if bus ();

    obs_ctrl #(
        .SPAWN_X   (9'd320),
        .MIN_GAP   (8'd20),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0 idle, 1 run, 2 halt.
    int m_state   = 0;
    int m_gap     = 0;
    int m_lfsr    = 0;
    int m_x [2]   = '{0, 0};
    bit m_act [2] = '{1'b0, 1'b0};
    bit m_spawn   = 1'b0;
    bit m_valid   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // The polynomial x^8+x^6+x^5+x^4+1 feeds back bits 7, 5, 4 and 3
    // into bit 0, and the register shifts left.
    function automatic int lfsr_next(input int l);
        int fb;
        fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
        return ((l << 1) | fb) & 'hFF;
    endfunction

    // Reference model, advanced once per rising edge.
    always @(posedge clk) begin : model
        int st, g, spd;
        int x [2];
        bit a [2];
        bit sp, found;
        st = m_state; g = m_gap; x = m_x; a = m_act; sp = 1'b0;
        if (rst) begin
            st = 0; g = MIN_GAP; x = '{0, 0}; a = '{1'b0, 1'b0};
            m_lfsr <= SEED;
        end else begin
            if (st == 1) begin
                if (bus.i_collide) begin
                    st = 2;
                end else if (bus.i_frame_tick) begin
                    spd = int'(bus.i_speed);
                    for (int i = 0; i < 2; i++) begin
                        if (a[i]) begin
                            if (x[i] < spd) begin a[i] = 1'b0; x[i] = 0; end
                            else x[i] = x[i] - spd;
                        end
                    end
                    if (g == 0) begin
                        found = 1'b0;
                        for (int i = 0; i < 2; i++) begin
                            if (!found && !a[i]) begin
                                found = 1'b1; a[i] = 1'b1; x[i] = SPAWN_X;
                            end
                        end
                        if (found) begin
                            g = MIN_GAP + (m_lfsr % 16);
                            if (g > 255) g = 255;
                            sp = 1'b1;
                        end
                    end else begin
                        g = g - 1;
                    end
                end
            end else if (bus.i_start) begin
                st = 1; g = MIN_GAP; x = '{0, 0}; a = '{1'b0, 1'b0};
            end
            m_lfsr <= lfsr_next(m_lfsr);
        end
        m_state <= st;
        m_gap   <= g;
        m_x     <= x;
        m_act   <= a;
        m_spawn <= sp;
        m_valid <= 1'b1;
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("state",   bus.o_state,   m_state);
            check("xpos0",   bus.o_xpos0,   m_x[0]);
            check("xpos1",   bus.o_xpos1,   m_x[1]);
            check("active0", bus.o_active0, m_act[0]);
            check("active1", bus.o_active1, m_act[1]);
            check("spawn",   bus.o_spawn,   m_spawn);
        end
    end

    // One frame tick at speed spd after 0..2 idle cycles.
    // On return, the outputs already reflect that tick.
    task automatic tick(input int spd);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.i_speed      = 4'(spd);
        bus.i_frame_tick = 1'b1;
        @(negedge clk);
        bus.i_frame_tick = 1'b0;
    endtask

    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    initial begin : stim
        bit got;
        int px0, px1;
        bus.i_frame_tick = 1'b0;
        bus.i_start      = 1'b0;
        bus.i_collide    = 1'b0;
        bus.i_speed      = 4'd0;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_state",   bus.o_state,   0);
        check("rst_xpos0",   bus.o_xpos0,   0);
        check("rst_active0", bus.o_active0, 0);
        check("rst_spawn",   bus.o_spawn,   0);
        check("model_lfsr_seed", m_lfsr, SEED);
        rst = 1'b0;
        @(negedge clk);
        // A5 = 1010_0101, feedback 1^1^0^0 = 0, so the next value is 0100_1010.
        check("model_lfsr_step", m_lfsr, 'h4A);

        // Start: RUN with empty slots. The gap counter counts 20 ticks down
        // to zero, and the following tick spawns into slot 0.
        pulse_start();
        check("start_state",   bus.o_state,   1);
        check("start_active0", bus.o_active0, 0);
        check("start_active1", bus.o_active1, 0);
        repeat (20) tick(0);
        check("gap_run_active0", bus.o_active0, 0);
        check("model_gap_zero",  m_gap, 0);
        tick(0);
        check("first_spawn",   bus.o_spawn,   1);
        check("first_xpos0",   bus.o_xpos0,   320);
        check("first_active0", bus.o_active0, 1);

        // Motion: 10 ticks at speed 3, then 5 ticks at speed 0.
        repeat (10) tick(3);
        check("motion_xpos0", bus.o_xpos0, 290);
        repeat (5) tick(0);
        check("still_xpos0", bus.o_xpos0, 290);

        // Retire: bring slot 0 down to 2 right after slot 1 spawns, then
        // retire it at speed 3. The gap is non-zero at that point.
        repeat (5) tick(15);
        check("move_xpos0", bus.o_xpos0, 215);
        got = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin tick(0); got = m_spawn; end
        check("slot1_spawned", bus.o_active1, 1);
        repeat (14) tick(15);
        tick(3);
        check("pre_retire_xpos0", bus.o_xpos0, 2);
        tick(3);
        check("retire_active0", bus.o_active0, 0);
        check("retire_xpos0",   bus.o_xpos0,   0);

        // Full: refill both slots with slot 0 ahead, wait out the gap with
        // both busy, then a retire in slot 0 must reload it immediately.
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick(15);
            got = !m_act[1] || (m_x[1] == SPAWN_X);
        end
        got = 1'b0;
        for (int k = 0; k < 80 && !got; k++) begin tick(0); got = m_act[0] && m_act[1]; end
        check("full_both_active", {bus.o_active0, bus.o_active1}, 2'b11);
        check("model_slot0_ahead", (m_x[0] <= m_x[1]), 1);
        for (int k = 0; k < 40 && m_gap != 0; k++) tick(0);
        check("model_full_gap", m_gap, 0);
        repeat (3) begin
            tick(0);
            check("full_no_spawn", bus.o_spawn, 0);
        end
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin tick(15); got = m_spawn; end
        check("refill_spawn", bus.o_spawn,   1);
        check("refill_xpos0", bus.o_xpos0,   320);
        check("refill_act0",  bus.o_active0, 1);

        // Collide on a tick cycle: HALT with the pre-edge positions.
        repeat (3) tick(2);
        px0 = m_x[0]; px1 = m_x[1];
        bus.i_frame_tick = 1'b1; bus.i_collide = 1'b1; bus.i_speed = 4'd7;
        @(negedge clk);
        bus.i_frame_tick = 1'b0;
        check("collide_state", bus.o_state, 2);
        check("collide_xpos0", bus.o_xpos0, px0);
        check("collide_xpos1", bus.o_xpos1, px1);
        repeat (10) tick(5);
        bus.i_collide = 1'b0;
        repeat (40) tick($urandom_range(1, 15));
        check("halt_state", bus.o_state, 2);
        check("halt_xpos0", bus.o_xpos0, px0);
        check("halt_xpos1", bus.o_xpos1, px1);
        pulse_start();
        check("restart_state", bus.o_state, 1);
        check("restart_slots", {bus.o_active0, bus.o_active1, bus.o_xpos0, bus.o_xpos1}, 0);

        // Start together with collide in RUN: collide wins.
        repeat (3) tick(2);
        bus.i_start = 1'b1; bus.i_collide = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0; bus.i_collide = 1'b0;
        check("start_collide_state", bus.o_state, 2);
        pulse_start();
        check("rerun_state", bus.o_state, 1);

        // Reset on a tick cycle mid-run. The LFSR restarts from the seed,
        // and later spawn gaps follow the restarted sequence.
        repeat (25) tick(4);
        bus.i_frame_tick = 1'b1; rst = 1'b1; bus.i_speed = 4'd4;
        @(negedge clk);
        bus.i_frame_tick = 1'b0; rst = 1'b0;
        check("midrst_state", bus.o_state, 0);
        check("midrst_slots", {bus.o_active0, bus.o_active1, bus.o_xpos0, bus.o_xpos1}, 0);
        check("midrst_spawn", bus.o_spawn, 0);
        check("model_lfsr_reseed", m_lfsr, SEED);
        pulse_start();
        repeat (60) tick($urandom_range(0, 6));

        // Randomised phase.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            bus.i_frame_tick = ($urandom_range(0, 2) == 0);
            bus.i_speed      = 4'($urandom_range(0, 15));
            bus.i_start      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 79) == 0)      bus.i_collide = 1'b1;
            else if ($urandom_range(0, 9) == 0)  bus.i_collide = 1'b0;
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        bus.i_frame_tick = 1'b0; bus.i_start = 1'b0; bus.i_collide = 1'b0; rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
